vga_fb_pixel_stream_pipelined: RTL and testbench



---
 rtl/vga_fb_pixel_stream_pipelined.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_vga_fb_pixel_stream_pipelined.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_pixel_stream_pipelined.sv
// VGA frame-buffer pixel streamer: walks VGA timing, reads visible pixels over AXI, emits valid/ready pixels.
// Latency: visible grant -> m_valid >= 3 cycles, blank pixel 2 cycles. Backpressure: m_ready low holds output, fills FIFOs, then stalls grants.
// Optional: VGA_FB_PIXEL_STREAM_PIXEL_DOUBLE_EN shows each frame-buffer word as a 2x2 screen block.

module vga_fb_pixel_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_dat,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_dat,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module vga_fb_pixel_stream_pipelined #(
   parameter int PIXEL_BITS      = 12,
   parameter int META_BITS       = 4,
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT_PORCH   = 16,
   parameter int H_SYNC_PULSE    = 96,
   parameter int H_BACK_PORCH    = 48,
   parameter int H_WHOLE_LINE    = 800,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT_PORCH   = 10,
   parameter int V_SYNC_PULSE    = 2,
   parameter int V_BACK_PORCH    = 33,
   parameter int V_WHOLE_FRAME   = 525,
   parameter int FB_WIDTH        = 640,
   parameter int AXI_ADDR_WIDTH  = 20,
   parameter int AXI_DATA_WIDTH  = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CTX_DEPTH       = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [AXI_ADDR_WIDTH-1:0]     fb_base,
   output logic                          frame_start,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          hsync,
   output logic                          vsync,
   output logic [PIXEL_BITS/3-1:0]       red,
   output logic [PIXEL_BITS/3-1:0]       grn,
   output logic [PIXEL_BITS/3-1:0]       blu,
   output logic [META_BITS-1:0]          meta,
   output logic [AXI_ADDR_WIDTH-1:0]     sram_axi_araddr,
   output logic                          sram_axi_arvalid,
   input  logic                          sram_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0]     sram_axi_rdata,
   input  logic [1:0]                    sram_axi_rresp,
   input  logic                          sram_axi_rvalid,
   output logic                          sram_axi_rready
);
   localparam int COLOR_W  = PIXEL_BITS / 3;
   localparam int WORD_W   = PIXEL_BITS + META_BITS;
   localparam int HCW      = $clog2(H_WHOLE_LINE);
   localparam int VCW      = $clog2(V_WHOLE_FRAME);
   localparam int OW       = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW       = OW + 2;
   localparam int HS_BEGIN = H_VISIBLE + H_FRONT_PORCH;
   localparam int HS_END   = HS_BEGIN + H_SYNC_PULSE;
   localparam int VS_BEGIN = V_VISIBLE + V_FRONT_PORCH;
   localparam int VS_END   = VS_BEGIN + V_SYNC_PULSE;

   typedef struct packed {
      logic visible;
      logic hsync;
      logic vsync;
   } ctx_t;

   logic [HCW-1:0]            col;
   logic [VCW-1:0]            row;
   logic [HCW-1:0]            col_f;
   logic [VCW-1:0]            row_f;
   logic [AXI_ADDR_WIDTH-1:0] base_q;
   logic [AXI_ADDR_WIDTH-1:0] base_sel;
   logic [AXI_ADDR_WIDTH-1:0] pix_addr;
   logic [OW-1:0]             out_cnt;
   logic [OW-1:0]             data_count;
   logic [SW-1:0]             inflight;
   logic                      discard;
   ctx_t                      cur_ctx;
   ctx_t                      ctx_head;
   logic                      at_origin;
   logic                      col_last;
   logic                      row_last;
   logic                      credit_ok;
   logic                      ar_free;
   logic                      grant;
   logic                      ar_hs;
   logic                      r_hs;
   logic                      ctx_empty;
   logic                      ctx_full;
   logic                      data_empty;
   logic                      out_load;
   logic                      blank_go;
   logic                      vis_go;
   logic [WORD_W-1:0]         data_head;
   logic                      data_unused_full;
   logic [$clog2(CTX_DEPTH+1)-1:0] ctx_unused_count;
   logic                      unused_bits;

   assign unused_bits     = ^{sram_axi_rresp, sram_axi_rdata, data_unused_full, ctx_unused_count};
   assign sram_axi_rready = 1'b1;

   assign cur_ctx.visible = (int'(col) < H_VISIBLE) && (int'(row) < V_VISIBLE);
   assign cur_ctx.hsync   = !((int'(col) >= HS_BEGIN) && (int'(col) < HS_END));
   assign cur_ctx.vsync   = !((int'(row) >= VS_BEGIN) && (int'(row) < VS_END));
   assign at_origin       = (col == '0) && (row == '0);
   assign col_last        = (int'(col) == H_WHOLE_LINE - 1);
   assign row_last        = (int'(row) == V_WHOLE_FRAME - 1);

`ifdef VGA_FB_PIXEL_STREAM_PIXEL_DOUBLE_EN
   assign col_f = col >> 1;
   assign row_f = row >> 1;
`else
   assign col_f = col;
   assign row_f = row;
`endif

   // Pixel (0,0) must already use the new frame's base, which lands in base_q at the same edge.
   assign base_sel = at_origin ? fb_base : base_q;
   assign pix_addr = base_sel + AXI_ADDR_WIDTH'(row_f) * AXI_ADDR_WIDTH'(FB_WIDTH)
                   + AXI_ADDR_WIDTH'(col_f);

   // Returned-but-unconsumed words also hold credit, so an always-ready R channel cannot overrun the data FIFO.
   assign inflight  = SW'(out_cnt) + SW'(sram_axi_arvalid) + SW'(data_count);
   assign credit_ok = inflight < SW'(MAX_OUTSTANDING);
   assign ar_free   = !sram_axi_arvalid || sram_axi_arready;
   assign grant     = enable && !ctx_full && (!cur_ctx.visible || (credit_ok && ar_free));
   assign ar_hs     = sram_axi_arvalid && sram_axi_arready;
   assign r_hs      = sram_axi_rvalid && sram_axi_rready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col         <= '0;
         row         <= '0;
         base_q      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= grant && at_origin;
         if (grant) begin
            if (at_origin) base_q <= fb_base;
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sram_axi_arvalid <= 1'b0;
         sram_axi_araddr  <= '0;
      end else if (grant && cur_ctx.visible) begin
         sram_axi_arvalid <= 1'b1;
         sram_axi_araddr  <= pix_addr;
      end else if (sram_axi_arready) begin
         sram_axi_arvalid <= 1'b0;
      end
   end

   // Responses to reads issued before a reset are dropped until this session issues its own first read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_cnt <= '0;
         discard <= 1'b1;
      end else begin
         if (grant && cur_ctx.visible) discard <= 1'b0;
         case ({ar_hs, r_hs})
            2'b10:   out_cnt <= out_cnt + 1'b1;
            2'b01:   out_cnt <= (out_cnt != '0) ? out_cnt - 1'b1 : out_cnt;
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   vga_fb_pixel_stream_fifo #(.WIDTH($bits(ctx_t)), .DEPTH(CTX_DEPTH)) u_ctx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (grant),
      .push_dat (cur_ctx),
      .pop      (blank_go || vis_go),
      .pop_dat  (ctx_head),
      .empty    (ctx_empty),
      .full     (ctx_full),
      .count    (ctx_unused_count)
   );

   vga_fb_pixel_stream_fifo #(.WIDTH(WORD_W), .DEPTH(MAX_OUTSTANDING)) u_data_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (r_hs && !discard),
      .push_dat (sram_axi_rdata[WORD_W-1:0]),
      .pop      (vis_go),
      .pop_dat  (data_head),
      .empty    (data_empty),
      .full     (data_unused_full),
      .count    (data_count)
   );

   assign out_load = !m_valid || m_ready;
   assign blank_go = out_load && !ctx_empty && !ctx_head.visible;
   assign vis_go   = out_load && !ctx_empty && ctx_head.visible && !data_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         red     <= '0;
         grn     <= '0;
         blu     <= '0;
         meta    <= '0;
      end else if (out_load) begin
         if (blank_go) begin
            m_valid <= 1'b1;
            hsync   <= ctx_head.hsync;
            vsync   <= ctx_head.vsync;
            red     <= '0;
            grn     <= '0;
            blu     <= '0;
            meta    <= '0;
         end else if (vis_go) begin
            m_valid <= 1'b1;
            hsync   <= ctx_head.hsync;
            vsync   <= ctx_head.vsync;
            red     <= data_head[PIXEL_BITS-1 -: COLOR_W];
            grn     <= data_head[PIXEL_BITS-COLOR_W-1 -: COLOR_W];
            blu     <= data_head[COLOR_W-1:0];
            meta    <= data_head[PIXEL_BITS +: META_BITS];
         end else begin
            m_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vga_fb_pixel_stream_pipelined.sv
// Randomized bench for vga_fb_pixel_stream_pipelined on a tiny 8x6 raster with a latency-configurable AXI memory.
module tb_vga_fb_pixel_stream_pipelined;
   localparam int HV = 4, HF = 1, HS = 1, HB = 2, HW = 8;
   localparam int VV = 3, VF = 1, VS = 1, VB = 1, VW = 6;
   localparam int FBW = 4, AW = 20, DW = 16, MAXO = 4, CTXD = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [AW-1:0] fb_base = '0;
   logic          m_ready = 1'b0;
   logic          arready = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = '0;
   logic          rvalid = 1'b0;
   logic          frame_start, m_valid, hsync, vsync, arvalid, rready;
   logic [3:0]    red, grn, blu, meta;
   logic [AW-1:0] araddr;

   vga_fb_pixel_stream_pipelined #(
      .PIXEL_BITS(12), .META_BITS(4),
      .H_VISIBLE(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_BACK_PORCH(HB), .H_WHOLE_LINE(HW),
      .V_VISIBLE(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_BACK_PORCH(VB), .V_WHOLE_FRAME(VW),
      .FB_WIDTH(FBW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
      .MAX_OUTSTANDING(MAXO), .CTX_DEPTH(CTXD)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .fb_base(fb_base),
      .frame_start(frame_start), .m_valid(m_valid), .m_ready(m_ready),
      .hsync(hsync), .vsync(vsync), .red(red), .grn(grn), .blu(blu), .meta(meta),
      .sram_axi_araddr(araddr), .sram_axi_arvalid(arvalid), .sram_axi_arready(arready),
      .sram_axi_rdata(rdata), .sram_axi_rresp(rresp), .sram_axi_rvalid(rvalid),
      .sram_axi_rready(rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dat;
      int          due;
   } resp_t;

   resp_t         rq[$];
   int            checks = 0, errors = 0;
   int            cyc = 0, lat_min = 1, lat_max = 1, ar_pct = 100, mr_pct = 100, en_drop_pct = 0;
   int            mr_hold = 0, en_hold = 0;
   bit            en_on = 0, first_change = 1;
   int            ar_idx = 0, ar_frame = 0, out_pos = 0, out_frame = 0, out_count = 0;
   logic [AW-1:0] base_of [256];
   int            max_inflight = 0, stable_err = 0, en_err = 0, rready_err = 0;
   bit            hold_prev = 0, ar_hold_prev = 0, arv_prev = 0, en_prev = 0;
   logic [17:0]   held = '0;
   logic [AW-1:0] held_addr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] t;
      t = {12'b0, a} * 32'h0000_9e37 + 32'h0000_1234;
      return t[15:0] ^ t[31:16];
   endfunction

   function automatic logic [AW-1:0] addr_of(input int f, input int r, input int c);
      int rr, cc;
      rr = r;
      cc = c;
`ifdef VGA_FB_PIXEL_STREAM_PIXEL_DOUBLE_EN
      rr = r / 2;
      cc = c / 2;
`endif
      return base_of[f % 256] + AW'(rr * FBW + cc);
   endfunction

   function automatic logic [31:0] exp_pix(input int f, input int pos);
      int r, c;
      logic vis, hs, vs;
      logic [15:0] w;
      r   = pos / HW;
      c   = pos % HW;
      vis = (c < HV) && (r < VV);
      hs  = !((c >= HV + HF) && (c < HV + HF + HS));
      vs  = !((r >= VV + VF) && (r < VV + VF + VS));
      w   = vis ? mem_word(addr_of(f, r, c)) : 16'h0;
      return {14'b0, hs, vs, w[11:0], w[15:12]};
   endfunction

   task automatic model_reset();
      ar_idx = 0; ar_frame = 0; out_pos = 0; out_frame = 0;
      base_of[0] = fb_base;
   endtask

   // Sampled mid-cycle: every handshake seen here completes at the coming rising edge.
   task automatic monitor();
      logic [17:0] cur;
      int d;
      cur = {hsync, vsync, red, grn, blu, meta};
      if (rvalid && rready) void'(rq.pop_front());
      if (reset) begin
         hold_prev = 0; ar_hold_prev = 0; arv_prev = arvalid; en_prev = enable;
         return;
      end
      if (rready !== 1'b1) rready_err++;
      if (hold_prev && (m_valid !== 1'b1 || cur !== held)) stable_err++;
      if (ar_hold_prev && (arvalid !== 1'b1 || araddr !== held_addr)) stable_err++;
      if (arvalid && !arv_prev && !en_prev) en_err++;
      hold_prev = m_valid && !m_ready; held = cur;
      ar_hold_prev = arvalid && !arready; held_addr = araddr;
      arv_prev = arvalid; en_prev = enable;
      if (frame_start) begin
         check("fs_arvalid", 32'(arvalid), 32'd1);
         check("fs_pos", 32'(ar_idx), 32'd0);
         check("fs_addr", 32'(araddr), 32'(base_of[ar_frame % 256]));
      end
      if (arvalid && arready) begin
         check("araddr", 32'(araddr), 32'(addr_of(ar_frame, ar_idx / HV, ar_idx % HV)));
         d = cyc + $urandom_range(lat_min, lat_max);
         if (rq.size() > 0 && rq[rq.size()-1].due > d) d = rq[rq.size()-1].due;
         rq.push_back('{dat: mem_word(araddr), due: d});
         ar_idx++;
         if (ar_idx == HV * VV) begin ar_idx = 0; ar_frame++; end
      end
      if (rq.size() > max_inflight) max_inflight = rq.size();
      if (m_valid && m_ready) begin
         check("pixel", {14'b0, cur}, exp_pix(out_frame, out_pos));
         out_count++;
         out_pos++;
         if (out_pos == 20) begin
            fb_base = first_change ? 20'h08000 : AW'($urandom_range(0, 20'hFFFFF));
            first_change = 0;
            base_of[(out_frame + 1) % 256] = fb_base;
         end
         if (out_pos == HW * VW) begin out_pos = 0; out_frame++; end
      end
   endtask

   task automatic drive();
      cyc++;
      arready = ($urandom_range(0, 99) < ar_pct);
      rvalid  = (rq.size() > 0) && (rq[0].due <= cyc);
      rdata   = rvalid ? rq[0].dat : 16'($urandom);
      rresp   = 2'($urandom);
      if (mr_hold > 0) begin
         m_ready = 1'b0;
         mr_hold--;
      end else begin
         m_ready = ($urandom_range(0, 99) < mr_pct);
      end
      if (en_hold == 0 && $urandom_range(0, 99) < en_drop_pct) en_hold = 5;
      if (en_hold > 0) begin
         enable = 1'b0;
         en_hold--;
      end else begin
         enable = en_on;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         monitor();
         @(posedge clk);
         #1;
         drive();
      end
   endtask

   initial begin
      int last;
      int n;
      run(3);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_arvalid", 32'(arvalid), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_rready", 32'(rready), 32'd1);
      model_reset();
      reset = 1'b0;
      en_on = 1;

      // Latency-1 memory, always-ready sink.
      run(300);
      check("progress_fast", 32'(out_count > 2 * HW * VW), 32'd1);

      // Slow memory: the read credit limit throttles the raster.
      lat_min = 10; lat_max = 10;
      last = out_count;
      run(400);
      check("progress_slow", 32'(out_count > last), 32'd1);

      // Random AR stalls, latencies, sink stalls and enable gaps.
      lat_min = 1; lat_max = 6; ar_pct = 70; mr_pct = 60; en_drop_pct = 3;
      last = out_count;
      run(300);
      mr_hold = 20;
      run(30);
      run(300);
      check("progress_random", 32'(out_count > last), 32'd1);

      // Reset with reads still in flight.
      lat_min = 10; lat_max = 10; ar_pct = 100; mr_pct = 100; en_drop_pct = 0; en_hold = 0;
      n = 0;
      while (rq.size() < 3 && n < 200) begin
         run(1);
         n++;
      end
      check("reset_setup_inflight", 32'(rq.size() >= 3), 32'd1);
      reset = 1'b1;
      en_on = 0;
      enable = 1'b0;
      #1;
      check("rst2_m_valid", 32'(m_valid), 32'd0);
      check("rst2_arvalid", 32'(arvalid), 32'd0);
      check("rst2_frame_start", 32'(frame_start), 32'd0);
      check("rst2_rready", 32'(rready), 32'd1);
      run(3);
      reset = 1'b0;
      model_reset();
      run(20);
      check("idle_m_valid", 32'(m_valid), 32'd0);
      check("idle_arvalid", 32'(arvalid), 32'd0);
      en_on = 1;
      last = out_count;
      run(300);
      check("progress_after_reset", 32'(out_count > last + HW * VW), 32'd1);

      check("max_inflight", 32'(max_inflight <= MAXO), 32'd1);
      check("hold_stability", 32'(stable_err), 32'd0);
      check("no_ar_while_disabled", 32'(en_err), 32'd0);
      check("rready_high", 32'(rready_err), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
